fetch_stage: RTL and testbench

- Fetch stage of the WISC-F24 single-issue core, directly upstream of decode.
- Owns the PC register and drives a variable-latency instruction memory through a request/done handshake.
- Delivers one 16-bit instruction plus PC+2 per accepted fetch to decode.
- Honours branch/jump redirects from the execute stage, downstream stall, and HALT.

---
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Fetch stage of the WISC-F24 single-issue core, sitting directly upstream
//   of decode. Owns the PC and drives a variable-latency instruction memory
//   with a one-cycle read strobe, then waits for the matching done pulse.
//   Every output is registered.
//
// Ports
//   clk          rising-edge system clock
//   rst          asynchronous, active-low reset
//   stall        decode cannot take a new instruction; no new request
//   redirect     execute took a branch/jump; load redirectPC
//   redirectPC   redirect target (must be halfword aligned)
//   imemData     instruction word, valid while imemDone=1
//   imemDone     memory completes the outstanding read this cycle
//   imemRd       one-cycle read request strobe
//   imemAddr     read address, valid while imemRd=1
//   instruction  instruction presented to decode (held between fetches)
//   pcPlus2      address of the held instruction + 2
//   instrValid   one-cycle pulse when instruction/pcPlus2 are new
//   halted       fetch has stopped after HALT or an error
//   err          sticky fault flag
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  output logic        imemRd,
  output logic [15:0] imemAddr,
  output logic [15:0] instruction,
  output logic [15:0] pcPlus2,
  output logic        instrValid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    stFetch = 2'd0,
    stWait  = 2'd1,
    stHalt  = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic [15:0] pc, pcNext;
  logic        dropFlag, dropNext;
  logic        firstCycle;
  logic        rdNext, validNext, errNext, haltedNext;
  logic [15:0] addrNext, instrNext, pcPlus2Next;
  logic        badRedirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= stFetch;
      pc          <= RESET_PC;
      dropFlag    <= 1'b0;
      firstCycle  <= 1'b1;
      imemRd      <= 1'b0;
      imemAddr    <= 16'h0000;
      instruction <= NOP_INSTR;
      pcPlus2     <= 16'h0000;
      instrValid  <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      dropFlag    <= dropNext;
      firstCycle  <= 1'b0;
      imemRd      <= rdNext;
      imemAddr    <= addrNext;
      instruction <= instrNext;
      pcPlus2     <= pcPlus2Next;
      instrValid  <= validNext;
      halted      <= haltedNext;
      err         <= errNext;
    end
  end

  // A done pulse in FETCH during the first cycle after reset belongs to a
  // request abandoned by the reset, so it is ignored rather than flagged.
  // A redirect that lands in WAIT marks the outstanding read for discard;
  // if the done arrives in the same cycle the redirect still wins.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    dropNext    = dropFlag;
    rdNext      = 1'b0;
    addrNext    = imemAddr;
    instrNext   = instruction;
    pcPlus2Next = pcPlus2;
    validNext   = 1'b0;
    errNext     = err;
    badRedirect = redirect && redirectPC[0];

    case (state)
      stFetch: begin
        if (badRedirect || (imemDone && !firstCycle)) begin
          errNext   = 1'b1;
          stateNext = stHalt;
        end else if (redirect) begin
          pcNext = redirectPC;
        end else if (!stall) begin
          rdNext    = 1'b1;
          addrNext  = pc;
          stateNext = stWait;
        end
      end

      stWait: begin
        if (badRedirect) begin
          errNext   = 1'b1;
          stateNext = stHalt;
        end else if (redirect) begin
          pcNext = redirectPC;
          if (imemDone) begin
            dropNext  = 1'b0;
            stateNext = stFetch;
          end else begin
            dropNext = 1'b1;
          end
        end else if (imemDone) begin
          if (dropFlag) begin
            dropNext  = 1'b0;
            stateNext = stFetch;
          end else begin
            instrNext   = imemData;
            pcPlus2Next = pc + 16'd2;
            validNext   = 1'b1;
            // HALT keeps the PC pointing at itself.
            if (imemData[15:11] == 5'b00000) begin
              stateNext = stHalt;
            end else begin
              pcNext    = pc + 16'd2;
              stateNext = stFetch;
            end
          end
        end
      end

      stHalt: begin
        if (imemDone) begin
          errNext = 1'b1;
        end
      end

      default: begin
        errNext   = 1'b1;
        stateNext = stHalt;
      end
    endcase

    haltedNext = (stateNext == stHalt);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Self-checking bench for fetch_stage: a directed vector table, a few
//   hand-written multi-cycle sequences, and randomized episodes checked
//   against a transaction-level reference model.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, imemDone;
  logic [15:0] redirectPC, imemData;
  logic        imemRd, instrValid, halted, err;
  logic [15:0] imemAddr, instruction, pcPlus2;

  int compared   = 0;
  int mismatched = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirectPC  (redirectPC),
    .imemData    (imemData),
    .imemDone    (imemDone),
    .imemRd      (imemRd),
    .imemAddr    (imemAddr),
    .instruction (instruction),
    .pcPlus2     (pcPlus2),
    .instrValid  (instrValid),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        dn;
    logic [15:0] data;
    logic        expRd;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expInstr;
    logic [15:0] expPp2;
    logic        expHalted;
    logic        expErr;
  } vec_t;

  vec_t vecs[20];

  // Reference model: a fetch unit is either idle, waiting on one read
  // (possibly marked to be thrown away), or stopped.
  bit          mWaiting, mDiscard, mHalted, mErr, mFirst;
  logic [15:0] mPc, mInstr, mPp2, eAddr;
  bit          eRd, eValid;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock once, land 1 unit after the edge.
  task automatic applyStimulus(input logic st, input logic rd,
                               input logic [15:0] rpc, input logic dn,
                               input logic [15:0] data);
    stall      = st;
    redirect   = rd;
    redirectPC = rpc;
    imemDone   = dn;
    imemData   = data;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mWaiting = 0; mDiscard = 0; mHalted = 0; mErr = 0; mFirst = 1;
    mPc = 16'h0000; mInstr = 16'h0800; mPp2 = 16'h0000;
    eRd = 0; eValid = 0; eAddr = 16'h0000;
  endtask

  task automatic modelStep(input logic st, input logic rd,
                           input logic [15:0] rpc, input logic dn,
                           input logic [15:0] data);
    eRd = 0;
    eValid = 0;
    if (mHalted) begin
      if (dn) mErr = 1;
    end else if (rd && rpc[0]) begin
      mErr = 1;
      mHalted = 1;
    end else if (!mWaiting) begin
      if (dn && !mFirst) begin
        mErr = 1;
        mHalted = 1;
      end else if (rd) begin
        mPc = rpc;
      end else if (!st) begin
        eRd = 1;
        eAddr = mPc;
        mWaiting = 1;
        mDiscard = 0;
      end
    end else begin
      if (rd) begin
        mPc = rpc;
        mDiscard = 1;
      end
      if (dn) begin
        if (!mDiscard) begin
          eValid = 1;
          mInstr = data;
          mPp2 = mPc + 16'd2;
          if (data[15:11] == 5'd0) mHalted = 1;
          else mPc = mPc + 16'd2;
        end
        mWaiting = 0;
        mDiscard = 0;
      end
    end
    mFirst = 0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " imemRd"}, {15'd0, imemRd}, 16'd0);
    checkOutput({tag, " instruction"}, instruction, 16'h0800);
    checkOutput({tag, " pcPlus2"}, pcPlus2, 16'h0000);
    checkOutput({tag, " instrValid"}, {15'd0, instrValid}, 16'd0);
    checkOutput({tag, " halted"}, {15'd0, halted}, 16'd0);
    checkOutput({tag, " err"}, {15'd0, err}, 16'd0);
  endtask

  task automatic resetDut();
    rst = 1'b0;
    stall = 0; redirect = 0; redirectPC = 0; imemDone = 0; imemData = 0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst = 1'b1;
    modelReset();
  endtask

  task automatic checkModel();
    checkOutput("rnd imemRd", {15'd0, imemRd}, {15'd0, eRd});
    if (eRd) checkOutput("rnd imemAddr", imemAddr, eAddr);
    checkOutput("rnd instrValid", {15'd0, instrValid}, {15'd0, eValid});
    checkOutput("rnd instruction", instruction, mInstr);
    checkOutput("rnd pcPlus2", pcPlus2, mPp2);
    checkOutput("rnd halted", {15'd0, halted}, {15'd0, mHalted});
    checkOutput("rnd err", {15'd0, err}, {15'd0, mErr});
  endtask

  initial begin
    int          countdown;
    logic        st, rd, dn;
    logic [15:0] rpc, data;

    // Directed table: streaming, redirect in WAIT, redirect with done, HALT.
    vecs[0]  = '{0,0,16'h0000,0,16'h0000, 1,16'h0000,0,16'h0800,16'h0000,0,0};
    vecs[1]  = '{0,0,16'h0000,1,16'h4101, 0,16'h0000,1,16'h4101,16'h0002,0,0};
    vecs[2]  = '{0,0,16'h0000,0,16'h0000, 1,16'h0002,0,16'h4101,16'h0002,0,0};
    vecs[3]  = '{0,0,16'h0000,1,16'h4101, 0,16'h0000,1,16'h4101,16'h0004,0,0};
    vecs[4]  = '{0,0,16'h0000,0,16'h0000, 1,16'h0004,0,16'h4101,16'h0004,0,0};
    vecs[5]  = '{0,0,16'h0000,1,16'h4101, 0,16'h0000,1,16'h4101,16'h0006,0,0};
    vecs[6]  = '{0,0,16'h0000,0,16'h0000, 1,16'h0006,0,16'h4101,16'h0006,0,0};
    vecs[7]  = '{0,1,16'h0040,0,16'h0000, 0,16'h0000,0,16'h4101,16'h0006,0,0};
    vecs[8]  = '{0,0,16'h0000,1,16'h5555, 0,16'h0000,0,16'h4101,16'h0006,0,0};
    vecs[9]  = '{0,0,16'h0000,0,16'h0000, 1,16'h0040,0,16'h4101,16'h0006,0,0};
    vecs[10] = '{0,1,16'h0080,1,16'h6666, 0,16'h0000,0,16'h4101,16'h0006,0,0};
    vecs[11] = '{0,0,16'h0000,0,16'h0000, 1,16'h0080,0,16'h4101,16'h0006,0,0};
    vecs[12] = '{0,0,16'h0000,1,16'h7123, 0,16'h0000,1,16'h7123,16'h0082,0,0};
    vecs[13] = '{0,1,16'h0010,0,16'h0000, 0,16'h0000,0,16'h7123,16'h0082,0,0};
    vecs[14] = '{1,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h7123,16'h0082,0,0};
    vecs[15] = '{0,0,16'h0000,0,16'h0000, 1,16'h0010,0,16'h7123,16'h0082,0,0};
    vecs[16] = '{0,0,16'h0000,1,16'h0000, 0,16'h0000,1,16'h0000,16'h0012,1,0};
    vecs[17] = '{0,1,16'h0020,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0012,1,0};
    vecs[18] = '{0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0012,1,0};
    vecs[19] = '{1,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0012,1,0};

    $display("[TB] directed vector table");
    resetDut();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].dn, vecs[i].data);
      checkOutput($sformatf("vec%0d imemRd", i), {15'd0, imemRd}, {15'd0, vecs[i].expRd});
      if (vecs[i].expRd)
        checkOutput($sformatf("vec%0d imemAddr", i), imemAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d instrValid", i), {15'd0, instrValid}, {15'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d instruction", i), instruction, vecs[i].expInstr);
      checkOutput($sformatf("vec%0d pcPlus2", i), pcPlus2, vecs[i].expPp2);
      checkOutput($sformatf("vec%0d halted", i), {15'd0, halted}, {15'd0, vecs[i].expHalted});
      checkOutput($sformatf("vec%0d err", i), {15'd0, err}, {15'd0, vecs[i].expErr});
    end

    // 3-cycle memory latency followed by a 4-cycle stall.
    $display("[TB] stall sequence");
    resetDut();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stall first imemRd", {15'd0, imemRd}, 16'd1);
    checkOutput("stall first imemAddr", imemAddr, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stall wait imemRd", {15'd0, imemRd}, 16'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stall wait instrValid", {15'd0, instrValid}, 16'd0);
    applyStimulus(0, 0, 0, 1, 16'h4101);
    checkOutput("stall deliver instrValid", {15'd0, instrValid}, 16'd1);
    checkOutput("stall deliver pcPlus2", pcPlus2, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("stalled%0d imemRd", i), {15'd0, imemRd}, 16'd0);
      checkOutput($sformatf("stalled%0d instruction", i), instruction, 16'h4101);
      checkOutput($sformatf("stalled%0d instrValid", i), {15'd0, instrValid}, 16'd0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("unstall imemRd", {15'd0, imemRd}, 16'd1);
    checkOutput("unstall imemAddr", imemAddr, 16'h0002);

    // PC wraps from 0xFFFE to 0x0000.
    $display("[TB] wrap sequence");
    resetDut();
    applyStimulus(0, 1, 16'hFFFE, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap imemAddr", imemAddr, 16'hFFFE);
    applyStimulus(0, 0, 0, 1, 16'h1234);
    checkOutput("wrap pcPlus2", pcPlus2, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap next imemRd", {15'd0, imemRd}, 16'd1);
    checkOutput("wrap next imemAddr", imemAddr, 16'h0000);

    // Late done: ignored in the first cycle after reset, an error after.
    $display("[TB] late done sequence");
    resetDut();
    applyStimulus(1, 0, 0, 1, 16'h4101);
    checkOutput("late first err", {15'd0, err}, 16'd0);
    checkOutput("late first halted", {15'd0, halted}, 16'd0);
    applyStimulus(1, 0, 0, 1, 16'h4101);
    checkOutput("late second err", {15'd0, err}, 16'd1);
    checkOutput("late second halted", {15'd0, halted}, 16'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("late no request", {15'd0, imemRd}, 16'd0);

    // Misaligned redirect, then asynchronous resets.
    $display("[TB] error and async reset sequence");
    resetDut();
    applyStimulus(0, 1, 16'h0031, 0, 0);
    checkOutput("misalign err", {15'd0, err}, 16'd1);
    checkOutput("misalign halted", {15'd0, halted}, 16'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("misalign no request", {15'd0, imemRd}, 16'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async err", {15'd0, err}, 16'd0);
    checkOutput("async halted", {15'd0, halted}, 16'd0);
    resetDut();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h4101);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midwait imemRd", {15'd0, imemRd}, 16'd1);
    #2 rst = 1'b0;
    #1;
    checkReset("async midwait");
    resetDut();

    // Randomized episodes against the reference model.
    $display("[TB] randomized episodes");
    for (int ep = 0; ep < 10; ep++) begin
      resetDut();
      countdown = -1;
      for (int cyc = 0; cyc < 150; cyc++) begin
        // Memory: a strobe seen now completes 0..2 cycles later.
        if (imemRd === 1'b1) countdown = $urandom_range(0, 2);
        dn = 1'b0;
        data = 16'h0000;
        if (countdown == 0) begin
          dn = 1'b1;
          countdown = -1;
          data = 16'($urandom);
          if ($urandom_range(0, 49) == 0) data[15:11] = 5'd0;
          else if (data[15:11] == 5'd0) data[15:11] = 5'd1;
        end else if (countdown > 0) begin
          countdown--;
        end
        st = ($urandom_range(0, 9) < 3);
        rd = ($urandom_range(0, 11) == 0);
        rpc = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 5) == 0) rpc = 16'hFFFE;
        if ($urandom_range(0, 15) == 0) rpc[0] = 1'b1;
        modelStep(st, rd, rpc, dn, data);
        applyStimulus(st, rd, rpc, dn, data);
        checkModel();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
